// File: rtl/seq_multiplier_signed_if.sv
// Request/response bundle of the sequential multiplier: operands and start in,
// busy/done status and the 2*WIDTH product out.
interface seq_multiplier_signed_if #(
    parameter int WIDTH = 16
);
    logic                 start;
    logic                 is_signed;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   res;

    modport master (output start, is_signed, A, B, input busy, done, res);
    modport slave  (input start, is_signed, A, B, output busy, done, res);
endinterface

// File: rtl/seq_multiplier_signed.sv
// Radix-2 shift-add multiplier on operand magnitudes with early termination;
// the sign is reapplied to the accumulated product when it is written out.
module seq_multiplier_signed #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    seq_multiplier_signed_if.slave bus
);
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

    state_t             r_state, w_next;
    logic [WIDTH-1:0]   r_maga, r_magb;
    logic [PW-1:0]      r_acc, r_res;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg, r_busy, r_done;

    logic [WIDTH-1:0]   w_absa, w_absb, w_magb_sh;
    logic [PW-1:0]      w_addend;
    logic               w_last;

    // Most-negative input maps to 2^(WIDTH-1), which is exact as unsigned.
    assign w_absa    = (bus.is_signed && bus.A[WIDTH-1]) ? (~bus.A + WIDTH'(1)) : bus.A;
    assign w_absb    = (bus.is_signed && bus.B[WIDTH-1]) ? (~bus.B + WIDTH'(1)) : bus.B;
    assign w_magb_sh = r_magb >> 1;
    assign w_addend  = {{WIDTH{1'b0}}, r_maga} << r_cnt;
    assign w_last    = (w_magb_sh == '0) || (r_cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_CALC;
            S_CALC:  if (w_last)    w_next = S_FIN;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_maga  <= '0;
            r_magb  <= '0;
            r_acc   <= '0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: if (bus.start) begin
                    r_maga <= w_absa;
                    r_magb <= w_absb;
                    r_neg  <= bus.is_signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                    r_acc  <= '0;
                    r_cnt  <= '0;
                    r_busy <= 1'b1;
                end
                S_CALC: begin
                    if (r_magb[0]) r_acc <= r_acc + w_addend;
                    r_magb <= w_magb_sh;
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (w_last) r_busy <= 1'b0;
                end
                S_FIN: begin
                    // Negating a zero accumulator yields zero, so no -0 case.
                    r_res  <= r_neg ? (~r_acc + PW'(1)) : r_acc;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.res  = r_res;
endmodule

// File: tb/tb_seq_multiplier_signed.sv
// Scoreboard bench: expected product/latency pushed at accept, checked on done.
module tb_seq_multiplier_signed;
    localparam int W = 16;

    typedef struct {
        logic [2*W-1:0] res;
        int             lat;
        int             acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_tst = 0;
    int   n_fail = 0;
    int   busy_cnt = 0;
    exp_t sb[$];

    seq_multiplier_signed_if #(.WIDTH(W)) bus ();

    seq_multiplier_signed #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tst++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*W-1:0] mdl_res(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg);
        longint sa, sb_;
        sa  = sg ? longint'($signed(a)) : longint'(a);
        sb_ = sg ? longint'($signed(b)) : longint'(b);
        return (2*W)'(sa * sb_);
    endfunction

    function automatic int mdl_lat(input logic [W-1:0] b, input logic sg);
        logic [W-1:0] m;
        int n;
        m = (sg && b[W-1]) ? -b : b;
        n = 1;
        for (int i = 0; i < W; i++) if (m[i]) n = i + 1;
        return n + 1;
    endfunction

    // Caller is positioned at a negedge; drives a one-cycle start, then scrambles
    // the operands and is_signed to show they were latched.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg, input bit push);
        exp_t e;
        bus.start = 1'b1; bus.A = a; bus.B = b; bus.is_signed = sg;
        @(posedge clk);
        #1;
        busy_cnt = 0;
        if (push) begin
            e.res = mdl_res(a, b, sg);
            e.lat = mdl_lat(b, sg);
            e.acc = cyc;
            sb.push_back(e);
        end
        bus.start = 1'b0;
        bus.A = W'($urandom);
        bus.B = W'($urandom);
        bus.is_signed = ~sg;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("drain_timeout", 64'(sb.size()), 64'd0);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("res", 64'(bus.res), 64'(e.res));
                chk("latency", 64'(cyc - e.acc), 64'(e.lat));
                chk("busy_cycles", 64'(busy_cnt), 64'(e.lat - 1));
                chk("busy_at_done", 64'(bus.busy), 64'd0);
            end
        end
        if (bus.busy) busy_cnt++;
    end

    initial begin
        int k;
        bus.start = 1'b1; bus.A = 16'h0003; bus.B = 16'h0003; bus.is_signed = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_res",  64'(bus.res),  64'd0);
        bus.start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Unsigned basics and worst case
        issue(16'h0003, 16'h0005, 1'b0, 1'b1); drain();
        issue(16'hFFFF, 16'hFFFF, 1'b0, 1'b1); drain();
        // Signed: negative operands and most-negative squared
        issue(16'hFFFD, 16'h0005, 1'b1, 1'b1); drain();
        issue(16'h8000, 16'h8000, 1'b1, 1'b1); drain();
        issue(16'h0005, 16'hFFFF, 1'b1, 1'b1); drain();
        issue(16'h8000, 16'h0001, 1'b1, 1'b1); drain();
        issue(16'h0000, 16'hFFF0, 1'b1, 1'b1); drain();

        // Zero multiplier, then back-to-back start in the done cycle
        issue(16'h1234, 16'h0000, 1'b0, 1'b1);
        k = 0;
        do begin @(negedge clk); k++; end while (!bus.done && k < 20);
        chk("b2b_done_seen", 64'(bus.done), 64'd1);
        issue(16'h0002, 16'h0002, 1'b0, 1'b1); drain();

        // Start while busy is ignored
        issue(16'h0007, 16'h00FF, 1'b0, 1'b1);
        @(negedge clk);
        bus.start = 1'b1; bus.A = 16'h0001; bus.B = 16'h0001;
        @(negedge clk);
        bus.start = 1'b0;
        drain();

        // Reset during the second CALC cycle aborts with no done
        issue(16'h0009, 16'h0009, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_res",  64'(bus.res),  64'd0);
        k = 0;
        repeat (8) begin @(negedge clk); if (bus.done) k++; end
        chk("abort_no_done", 64'(k), 64'd0);
        issue(16'h0009, 16'h0009, 1'b0, 1'b1); drain();

        // Random mix
        for (int i = 0; i < 20; i++) begin
            issue(W'($urandom), W'($urandom >> $urandom_range(0, 16)), 1'($urandom), 1'b1);
            drain();
        end

        $display("[TB] %0d tests run, %0d failed", n_tst, n_fail);
        $finish;
    end
endmodule
